// File: rtl/ex_mem_reg.sv
// ex_mem_reg : EX/MEM pipeline register, directly downstream of the ALU.
//
// Captures the ALU result, store data, destination register and the MEM/WB
// control bits on every rising edge. A flush loads a bubble, a stall holds
// everything, and otherwise the EX-stage values are captured.
//
// Ports
//   clk_i        rising-edge clock
//   rst_i        asynchronous active-low reset
//   stall_i      hold all registered contents
//   flush_i      replace contents with a bubble (wins over stall_i)
//   valid_i      EX stage holds a real instruction
//   ALUResult_i  ALU result
//   MemData_i    forwarded rs2 value for stores
//   RDaddr_i     destination register
//   RegWrite_i, MemtoReg_i, MemRead_i, MemWrite_i   MEM/WB controls
//   valid_o, ALUResult_o, MemData_o, RDaddr_o,
//   RegWrite_o, MemtoReg_o, MemRead_o, MemWrite_o    registered copies
//   FwdEn_o      RegWrite_o & valid_o & (RDaddr_o != 0), from registers only
//   InstCnt_o    count of valid instructions captured (wraps modulo 2^CNT_W)

module ex_mem_reg #(
   parameter int DATA_W = 32,
   parameter int REG_AW = 5,
   parameter int CNT_W  = 32
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              stall_i,
   input  logic              flush_i,
   input  logic              valid_i,
   input  logic [DATA_W-1:0] ALUResult_i,
   input  logic [DATA_W-1:0] MemData_i,
   input  logic [REG_AW-1:0] RDaddr_i,
   input  logic              RegWrite_i,
   input  logic              MemtoReg_i,
   input  logic              MemRead_i,
   input  logic              MemWrite_i,
   output logic              valid_o,
   output logic [DATA_W-1:0] ALUResult_o,
   output logic [DATA_W-1:0] MemData_o,
   output logic [REG_AW-1:0] RDaddr_o,
   output logic              RegWrite_o,
   output logic              MemtoReg_o,
   output logic              MemRead_o,
   output logic              MemWrite_o,
   output logic              FwdEn_o,
   output logic [CNT_W-1:0]  InstCnt_o
);

   logic              r_valid;
   logic [DATA_W-1:0] r_alu_result;
   logic [DATA_W-1:0] r_mem_data;
   logic [REG_AW-1:0] r_rd_addr;
   logic              r_reg_write;
   logic              r_mem_to_reg;
   logic              r_mem_read;
   logic              r_mem_write;
   logic [CNT_W-1:0]  r_inst_cnt;

   logic              w_rd_nonzero;

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         r_valid      <= 1'b0;
         r_alu_result <= '0;
         r_mem_data   <= '0;
         r_rd_addr    <= '0;
         r_reg_write  <= 1'b0;
         r_mem_to_reg <= 1'b0;
         r_mem_read   <= 1'b0;
         r_mem_write  <= 1'b0;
         r_inst_cnt   <= '0;
      end else if (flush_i) begin
         // Bubble: counter keeps its value, everything else clears.
         r_valid      <= 1'b0;
         r_alu_result <= '0;
         r_mem_data   <= '0;
         r_rd_addr    <= '0;
         r_reg_write  <= 1'b0;
         r_mem_to_reg <= 1'b0;
         r_mem_read   <= 1'b0;
         r_mem_write  <= 1'b0;
      end else if (!stall_i) begin
         r_valid      <= valid_i;
         r_alu_result <= ALUResult_i;
         r_mem_data   <= MemData_i;
         r_rd_addr    <= RDaddr_i;
         // An invalid slot must never write memory or the register file;
         // data fields are still captured. Illegal MemRead+MemWrite passes as-is.
         r_reg_write  <= RegWrite_i & valid_i;
         r_mem_to_reg <= MemtoReg_i & valid_i;
         r_mem_read   <= MemRead_i  & valid_i;
         r_mem_write  <= MemWrite_i & valid_i;
         if (valid_i) begin
            r_inst_cnt <= r_inst_cnt + 1'b1;
         end
      end
   end

   assign w_rd_nonzero = (r_rd_addr != '0);

   assign valid_o     = r_valid;
   assign ALUResult_o = r_alu_result;
   assign MemData_o   = r_mem_data;
   assign RDaddr_o    = r_rd_addr;
   assign RegWrite_o  = r_reg_write;
   assign MemtoReg_o  = r_mem_to_reg;
   assign MemRead_o   = r_mem_read;
   assign MemWrite_o  = r_mem_write;
   assign FwdEn_o     = r_reg_write & r_valid & w_rd_nonzero;
   assign InstCnt_o   = r_inst_cnt;

endmodule

// File: tb/tb_ex_mem_reg.sv
module tb_ex_mem_reg;

   logic        clk_i = 1'b0;
   logic        rst_i;
   logic        stall_i, flush_i, valid_i;
   logic [31:0] ALUResult_i, MemData_i;
   logic [4:0]  RDaddr_i;
   logic        RegWrite_i, MemtoReg_i, MemRead_i, MemWrite_i;

   logic        valid_o, RegWrite_o, MemtoReg_o, MemRead_o, MemWrite_o, FwdEn_o;
   logic [31:0] ALUResult_o, MemData_o, InstCnt_o;
   logic [4:0]  RDaddr_o;

   // Second instance with a 4-bit counter to exercise the wrap.
   logic        s_valid_o, s_RegWrite_o, s_MemtoReg_o, s_MemRead_o, s_MemWrite_o, s_FwdEn_o;
   logic [31:0] s_ALUResult_o, s_MemData_o;
   logic [4:0]  s_RDaddr_o;
   logic [3:0]  s_InstCnt_o;

   always #5 clk_i = ~clk_i;

   ex_mem_reg dut (
      .clk_i(clk_i), .rst_i(rst_i), .stall_i(stall_i), .flush_i(flush_i),
      .valid_i(valid_i), .ALUResult_i(ALUResult_i), .MemData_i(MemData_i),
      .RDaddr_i(RDaddr_i), .RegWrite_i(RegWrite_i), .MemtoReg_i(MemtoReg_i),
      .MemRead_i(MemRead_i), .MemWrite_i(MemWrite_i),
      .valid_o(valid_o), .ALUResult_o(ALUResult_o), .MemData_o(MemData_o),
      .RDaddr_o(RDaddr_o), .RegWrite_o(RegWrite_o), .MemtoReg_o(MemtoReg_o),
      .MemRead_o(MemRead_o), .MemWrite_o(MemWrite_o), .FwdEn_o(FwdEn_o),
      .InstCnt_o(InstCnt_o)
   );

   ex_mem_reg #(.CNT_W(4)) dut_s (
      .clk_i(clk_i), .rst_i(rst_i), .stall_i(stall_i), .flush_i(flush_i),
      .valid_i(valid_i), .ALUResult_i(ALUResult_i), .MemData_i(MemData_i),
      .RDaddr_i(RDaddr_i), .RegWrite_i(RegWrite_i), .MemtoReg_i(MemtoReg_i),
      .MemRead_i(MemRead_i), .MemWrite_i(MemWrite_i),
      .valid_o(s_valid_o), .ALUResult_o(s_ALUResult_o), .MemData_o(s_MemData_o),
      .RDaddr_o(s_RDaddr_o), .RegWrite_o(s_RegWrite_o), .MemtoReg_o(s_MemtoReg_o),
      .MemRead_o(s_MemRead_o), .MemWrite_o(s_MemWrite_o), .FwdEn_o(s_FwdEn_o),
      .InstCnt_o(s_InstCnt_o)
   );

   typedef struct {
      logic        v;
      logic [31:0] alu;
      logic [31:0] md;
      logic [4:0]  rd;
      logic        rw, mtr, mr, mw;
      logic [31:0] cnt;
   } exp_t;

   exp_t m;
   exp_t q[$];
   int   errors = 0;
   int   checks = 0;
   int   wrap_seen = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      m.v = 0; m.alu = 0; m.md = 0; m.rd = 0;
      m.rw = 0; m.mtr = 0; m.mr = 0; m.mw = 0; m.cnt = 0;
   endtask

   task automatic check_out(input string tag);
      exp_t e;
      logic fwd;
      if (q.size() == 0) begin
         checks++;
         errors++;
         $error("FAIL %s scoreboard empty observed=0 expected=1", tag);
         return;
      end
      e = q.pop_front();
      fwd = e.rw & e.v & (e.rd != 5'd0);
      chk({tag, ".valid"},  32'(valid_o),     32'(e.v));
      chk({tag, ".alu"},    ALUResult_o,      e.alu);
      chk({tag, ".md"},     MemData_o,        e.md);
      chk({tag, ".rd"},     32'(RDaddr_o),    32'(e.rd));
      chk({tag, ".ctl"},    {28'd0, RegWrite_o, MemtoReg_o, MemRead_o, MemWrite_o},
                            {28'd0, e.rw, e.mtr, e.mr, e.mw});
      chk({tag, ".fwd"},    32'(FwdEn_o),     32'(fwd));
      chk({tag, ".cnt"},    InstCnt_o,        e.cnt);
      chk({tag, ".s_cnt"},  32'(s_InstCnt_o), 32'(e.cnt[3:0]));
      chk({tag, ".s_alu"},  s_ALUResult_o,    e.alu);
      chk({tag, ".s_fwd"},  32'(s_FwdEn_o),   32'(fwd));
   endtask

   // Drive one cycle of stimulus, predict the post-edge state, then compare.
   task automatic step(input string tag, input logic st, input logic fl, input logic v,
                       input logic [31:0] alu, input logic [31:0] md, input logic [4:0] rd,
                       input logic rw, input logic mtr, input logic mr, input logic mw);
      stall_i = st; flush_i = fl; valid_i = v;
      ALUResult_i = alu; MemData_i = md; RDaddr_i = rd;
      RegWrite_i = rw; MemtoReg_i = mtr; MemRead_i = mr; MemWrite_i = mw;
      if (fl) begin
         m.v = 0; m.alu = 0; m.md = 0; m.rd = 0;
         m.rw = 0; m.mtr = 0; m.mr = 0; m.mw = 0;
      end else if (!st) begin
         m.v = v; m.alu = alu; m.md = md; m.rd = rd;
         m.rw = rw & v; m.mtr = mtr & v; m.mr = mr & v; m.mw = mw & v;
         if (v) begin
            m.cnt = m.cnt + 32'd1;
            if (m.cnt[3:0] == 4'd0) wrap_seen++;
         end
      end
      q.push_back(m);
      @(posedge clk_i);
      #1;
      check_out(tag);
   endtask

   initial begin
      rst_i = 1'b0;
      stall_i = 0; flush_i = 0; valid_i = 0;
      ALUResult_i = 0; MemData_i = 0; RDaddr_i = 0;
      RegWrite_i = 0; MemtoReg_i = 0; MemRead_i = 0; MemWrite_i = 0;
      model_reset();
      #12;
      q.push_back(m);
      check_out("reset_init");
      rst_i = 1'b1;

      step("load",     0, 0, 1, 32'h0000_0007, 32'h0, 5'd5, 1, 0, 0, 0);

      step("stall_cap", 0, 0, 1, 32'hAAAA_0001, 32'h11, 5'd3, 1, 1, 1, 0);
      for (int i = 0; i < 3; i++)
         step("stall_hold", 1, 0, 1, 32'hBBBB_0002, 32'h22, 5'd4, 1, 0, 0, 1);
      step("stall_rel", 0, 0, 1, 32'hBBBB_0002, 32'h22, 5'd4, 1, 0, 0, 1);

      step("flush_prio", 1, 1, 1, 32'h5555_5555, 32'h66, 5'd7, 1, 1, 0, 1);
      step("flush_only", 0, 1, 1, 32'h1, 32'h2, 5'd8, 1, 0, 1, 0);

      step("bubble",   0, 0, 0, 32'hCAFE_0000, 32'h77, 5'd9, 1, 1, 1, 1);
      step("x0",       0, 0, 1, 32'h0000_0099, 32'h0, 5'd0, 1, 0, 0, 0);
      step("rd_wr",    0, 0, 1, 32'h0000_0100, 32'h88, 5'd2, 0, 0, 1, 1);
      step("rd31",     0, 0, 1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd31, 1, 1, 0, 0);

      for (int i = 0; i < 30; i++) begin
         logic [9:0] r;
         r = 10'($urandom);
         step("rand", r[0] & r[1], r[2] & r[3] & r[4], r[5] | r[6],
              $urandom, $urandom, 5'($urandom), r[7], r[8], r[9], r[7] ^ r[8]);
      end

      // Enough consecutive valid loads to roll the 4-bit counter over.
      for (int i = 0; i < 20; i++)
         step("wrap", 0, 0, 1, 32'(i), 32'(i + 100), 5'(i + 1), 1, 0, 0, 0);
      checks++;
      assert (wrap_seen > 0) else begin
         errors++;
         $error("FAIL wrap_occurred observed=%0d expected>0", wrap_seen);
      end

      // Asynchronous reset between edges while outputs hold 0x1234.
      step("pre_rst", 0, 0, 1, 32'h0000_1234, 32'h0000_1234, 5'd6, 1, 1, 0, 0);
      stall_i = 1;
      #2;
      rst_i = 1'b0;
      #1;
      model_reset();
      q.push_back(m);
      check_out("async_rst");
      @(negedge clk_i);
      rst_i = 1'b1;
      stall_i = 0;

      step("post_rst", 0, 0, 1, 32'h0000_0042, 32'h0, 5'd1, 1, 0, 0, 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
